load_store_unit: RTL and testbench

Parametrised load/store unit for the CPU data-memory port, replacing the single-cycle direct memory wiring with a handshaked, multi-cycle access engine. It accepts one byte/half/word (and double when XLEN=64) request from the core, performs lane alignment, byte masking and sign/zero extension, and splits misaligned accesses into two aligned bus beats. A mode parameter selects trapping instead of splitting. It sits between the core's execute stage and data memory; the core stalls while `req_ready` is low.

---
 rtl/load_store_unit_pkg.sv | 21 ++
 rtl/load_store_unit_if.sv | 42 ++++
 rtl/load_store_unit_lane_align.sv | 39 +++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the size-to-byte-count decode.
package load_store_unit_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;
  localparam logic [1:0] LSU_SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory beat signals of the load/store unit.
// The LSU uses the slave modport; the core/memory environment uses master.
interface load_store_unit_if
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
);
  localparam int NB = XLEN / 8;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_uext;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_fault;
  logic            mem_valid;
  logic            mem_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [NB-1:0]   mem_wmask;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_uext, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_valid, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_uext, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_valid, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering: byte mask and store data for a beat, and the
// read data of a beat shifted down and merged with the previous beat.
module lsu_lane_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0]   off,
  input  logic [3:0]      bytes,
  input  logic            wbeat,
  input  logic [XLEN-1:0] wdata,
  output logic [NB-1:0]   mask,
  output logic [XLEN-1:0] wdata_sh,
  input  logic            rbeat,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] racc,
  output logic [XLEN-1:0] rdata_sh
);

  logic [2*NB-1:0]   ones;
  logic [2*NB-1:0]   mask_w;
  logic [2*XLEN-1:0] wdata_w;
  logic [2*XLEN-1:0] rdata_w;

  // Double-width shifts: the low half is beat 0, the high half spills into beat 1.
  always_comb begin
    ones = '0;
    for (int i = 0; i < 2*NB; i++) ones[i] = (i < int'(bytes));
    mask_w   = ones << off;
    wdata_w  = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    rdata_w  = {rdata, {XLEN{1'b0}}} >> {off, 3'b000};
    mask     = wbeat ? mask_w[2*NB-1:NB] : mask_w[NB-1:0];
    wdata_sh = wbeat ? wdata_w[2*XLEN-1:XLEN] : wdata_w[XLEN-1:0];
    rdata_sh = rbeat ? (racc | rdata_w[XLEN-1:0]) : rdata_w[2*XLEN-1:XLEN];
  end

endmodule

// File: rtl/load_store_unit.sv
// Handshaked load/store engine: aligns, masks and extends core accesses and
// splits boundary-crossing ones into two aligned memory beats (or faults them).
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit MISALIGNED_SPLIT = 1'b1
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  lsu_state_e      state;
  logic            we_q, uext_q, cross_q;
  logic [OW-1:0]   off_q;
  logic [3:0]      bytes_q;
  logic [XLEN-1:0] wdata_q, acc_q;

  logic            idle, cross_in, fault_in;
  logic [OW-1:0]   off_in, off_sel;
  logic [3:0]      bytes_in, bytes_sel;
  logic [XLEN-1:0] wdata_sel, wdata_nx, rdata_mg;
  logic [NB-1:0]   mask_nx;

  assign idle      = (state == ST_IDLE);
  assign off_in    = bus.req_addr[OW-1:0];
  assign bytes_in  = size_bytes(bus.req_size);
  assign cross_in  = (int'(off_in) + int'(bytes_in)) > NB;
  assign fault_in  = ((XLEN == 32) && (bus.req_size == LSU_SIZE_D)) ||
                     (cross_in && !MISALIGNED_SPLIT);
  assign off_sel   = idle ? off_in : off_q;
  assign bytes_sel = idle ? bytes_in : bytes_q;
  assign wdata_sel = idle ? bus.req_wdata : wdata_q;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .off      (off_sel),
    .bytes    (bytes_sel),
    .wbeat    (state == ST_BEAT0),
    .wdata    (wdata_sel),
    .mask     (mask_nx),
    .wdata_sh (wdata_nx),
    .rbeat    (state == ST_BEAT1),
    .rdata    (bus.mem_rdata),
    .racc     (acc_q),
    .rdata_sh (rdata_mg)
  );

  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] d,
                                                  input logic [3:0] nb,
                                                  input logic uext);
    logic            sign;
    logic [XLEN-1:0] r;
    case (nb)
      4'd1:    sign = d[7];
      4'd2:    sign = d[15];
      4'd4:    sign = d[31];
      default: sign = d[XLEN-1];
    endcase
    for (int i = 0; i < XLEN; i++) r[i] = (i < 8*int'(nb)) ? d[i] : (sign & ~uext);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (idle && bus.req_valid) begin
      we_q    <= bus.req_we;
      uext_q  <= bus.req_uext;
      off_q   <= off_in;
      bytes_q <= bytes_in;
      wdata_q <= bus.req_wdata;
      cross_q <= cross_in;
    end
    if (state == ST_BEAT0 && bus.mem_ready) acc_q <= rdata_mg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_fault <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_valid  <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wmask  <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.req_valid) begin
          bus.req_ready <= 1'b0;
          if (fault_in) begin
            state          <= ST_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_fault <= 1'b1;
            bus.resp_rdata <= '0;
          end else begin
            state         <= ST_BEAT0;
            bus.mem_valid <= 1'b1;
            bus.mem_we    <= bus.req_we;
            bus.mem_addr  <= {bus.req_addr[XLEN-1:OW], {OW{1'b0}}};
            bus.mem_wmask <= mask_nx;
            bus.mem_wdata <= bus.req_we ? wdata_nx : '0;
          end
        end
        ST_BEAT0: if (bus.mem_ready) begin
          if (cross_q) begin
            state         <= ST_BEAT1;
            bus.mem_addr  <= bus.mem_addr + XLEN'(NB);
            bus.mem_wmask <= mask_nx;
            bus.mem_wdata <= we_q ? wdata_nx : '0;
          end else begin
            state          <= ST_RESP;
            bus.mem_valid  <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_fault <= 1'b0;
            bus.resp_rdata <= we_q ? '0 : extend_load(rdata_mg, bytes_q, uext_q);
          end
        end
        ST_BEAT1: if (bus.mem_ready) begin
          state          <= ST_RESP;
          bus.mem_valid  <= 1'b0;
          bus.mem_we     <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_fault <= 1'b0;
          bus.resp_rdata <= we_q ? '0 : extend_load(rdata_mg, bytes_q, uext_q);
        end
        ST_RESP: begin
          state          <= ST_IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_fault <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=32): one DUT with splitting, one
// with misaligned accesses faulting; a scripted memory answers each beat.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.XLEN(32)) bus_sp ();
  load_store_unit_if #(.XLEN(32)) bus_ns ();

  load_store_unit #(.XLEN(32), .MISALIGNED_SPLIT(1'b1)) dut_sp (.clk(clk), .reset(reset), .bus(bus_sp));
  load_store_unit #(.XLEN(32), .MISALIGNED_SPLIT(1'b0)) dut_ns (.clk(clk), .reset(reset), .bus(bus_ns));

  int tests_run = 0;
  int tests_failed = 0;

  int          nbeats, resp_cyc, nresp;
  logic [31:0] b_addr [2];
  logic [3:0]  b_mask [2];
  logic [31:0] b_wdata [2];
  logic        b_we [2];
  logic [31:0] r_rdata;
  logic        r_fault, stable, rdy_low, after_rv, after_rdy, accept_rdy;

  task automatic do_access(input bit sel, input bit we, input logic [1:0] size, input bit uext,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd0, input logic [31:0] rd1, input int waits);
    logic mv, mwe, rv, rr, rf;
    logic [31:0] ma, mw, rd;
    logic [3:0] mm;
    bit active, hs, done;
    int w;
    nbeats = 0; resp_cyc = -1; nresp = 0; stable = 1; rdy_low = 1;
    after_rv = 1; after_rdy = 0; r_rdata = 'x; r_fault = 'x;
    for (int i = 0; i < 2; i++) begin b_addr[i] = 'x; b_mask[i] = 'x; b_wdata[i] = 'x; b_we[i] = 'x; end
    @(negedge clk);
    accept_rdy = sel ? bus_ns.req_ready : bus_sp.req_ready;
    bus_sp.req_we = we; bus_sp.req_size = size; bus_sp.req_uext = uext;
    bus_sp.req_addr = addr; bus_sp.req_wdata = wdata;
    bus_ns.req_we = we; bus_ns.req_size = size; bus_ns.req_uext = uext;
    bus_ns.req_addr = addr; bus_ns.req_wdata = wdata;
    bus_sp.req_valid = !sel; bus_ns.req_valid = sel;
    @(posedge clk);
    @(negedge clk);
    bus_sp.req_valid = 1'b0; bus_ns.req_valid = 1'b0;
    bus_sp.req_addr = 32'hFFFF_FFFF; bus_ns.req_addr = 32'hFFFF_FFFF;
    active = 0; hs = 0; done = 0; w = 0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      mv  = sel ? bus_ns.mem_valid : bus_sp.mem_valid;
      mwe = sel ? bus_ns.mem_we : bus_sp.mem_we;
      ma  = sel ? bus_ns.mem_addr : bus_sp.mem_addr;
      mm  = sel ? bus_ns.mem_wmask : bus_sp.mem_wmask;
      mw  = sel ? bus_ns.mem_wdata : bus_sp.mem_wdata;
      rv  = sel ? bus_ns.resp_valid : bus_sp.resp_valid;
      rr  = sel ? bus_ns.req_ready : bus_sp.req_ready;
      rd  = sel ? bus_ns.resp_rdata : bus_sp.resp_rdata;
      rf  = sel ? bus_ns.resp_fault : bus_sp.resp_fault;
      bus_sp.mem_ready = 1'b0; bus_ns.mem_ready = 1'b0;
      bus_sp.mem_rdata = 32'hA5A5_A5A5; bus_ns.mem_rdata = 32'hA5A5_A5A5;
      if (nresp > 0) begin
        after_rv = rv; after_rdy = rr; done = 1;
      end else begin
        if (rv) begin
          nresp++; resp_cyc = cyc; r_rdata = rd; r_fault = rf;
          if (rr) rdy_low = 0;
        end
        if (mv) begin
          if (rr) rdy_low = 0;
          if (!active) begin
            active = 1; w = 0;
            if (nbeats < 2) begin
              b_addr[nbeats] = ma; b_mask[nbeats] = mm; b_wdata[nbeats] = mw; b_we[nbeats] = mwe;
            end
          end else if (nbeats < 2 && (ma !== b_addr[nbeats] || mm !== b_mask[nbeats] ||
                                       mw !== b_wdata[nbeats] || mwe !== b_we[nbeats])) begin
            stable = 0;
          end
          if (w == waits) begin
            hs = 1;
            if (sel) begin bus_ns.mem_ready = 1'b1; bus_ns.mem_rdata = (nbeats == 0) ? rd0 : rd1; end
            else     begin bus_sp.mem_ready = 1'b1; bus_sp.mem_rdata = (nbeats == 0) ? rd0 : rd1; end
          end else begin
            w++;
          end
        end
      end
      @(posedge clk);
      if (hs) begin nbeats++; active = 0; hs = 0; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus_sp.req_valid = 0; bus_sp.req_we = 0; bus_sp.req_size = 0; bus_sp.req_uext = 0;
    bus_sp.req_addr = 0; bus_sp.req_wdata = 0; bus_sp.mem_ready = 0; bus_sp.mem_rdata = 0;
    bus_ns.req_valid = 0; bus_ns.req_we = 0; bus_ns.req_size = 0; bus_ns.req_uext = 0;
    bus_ns.req_addr = 0; bus_ns.req_wdata = 0; bus_ns.mem_ready = 0; bus_ns.mem_rdata = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (bus_sp.req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_req_ready: got %b expected 1", bus_sp.req_ready); end
    tests_run++; if (bus_sp.resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_resp_valid: got %b expected 0", bus_sp.resp_valid); end
    tests_run++; if (bus_sp.resp_fault !== 1'b0) begin tests_failed++; $display("FAIL rst_resp_fault: got %b expected 0", bus_sp.resp_fault); end
    tests_run++; if (bus_sp.resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_resp_rdata: got %h expected 0", bus_sp.resp_rdata); end
    tests_run++; if (bus_sp.mem_valid !== 1'b0 || bus_sp.mem_we !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_valid_we: got %b%b expected 00", bus_sp.mem_valid, bus_sp.mem_we); end
    tests_run++; if (bus_sp.mem_addr !== 32'h0 || bus_sp.mem_wmask !== 4'h0 || bus_sp.mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL rst_mem_fields: got %h/%h/%h expected 0/0/0", bus_sp.mem_addr, bus_sp.mem_wmask, bus_sp.mem_wdata); end
    tests_run++; if (bus_ns.req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ns_req_ready: got %b expected 1", bus_ns.req_ready); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_word;
    do_access(0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0, 0);
    tests_run++; if (accept_rdy !== 1'b1) begin tests_failed++; $display("FAIL sw_idle_ready: got %b expected 1", accept_rdy); end
    tests_run++; if (nbeats !== 1) begin tests_failed++; $display("FAIL sw_beats: got %0d expected 1", nbeats); end
    tests_run++; if (b_addr[0] !== 32'h100 || b_we[0] !== 1'b1) begin tests_failed++; $display("FAIL sw_addr_we: got %h/%b expected 00000100/1", b_addr[0], b_we[0]); end
    tests_run++; if (b_mask[0] !== 4'b1111) begin tests_failed++; $display("FAIL sw_mask: got %b expected 1111", b_mask[0]); end
    tests_run++; if (b_wdata[0] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sw_wdata: got %h expected deadbeef", b_wdata[0]); end
    tests_run++; if (resp_cyc !== 2 || r_fault !== 1'b0 || r_rdata !== 32'h0) begin tests_failed++; $display("FAIL sw_resp: got cyc %0d fault %b rdata %h expected 2/0/0", resp_cyc, r_fault, r_rdata); end
  endtask

  task automatic test_load_extend;
    do_access(0, 0, 2'b00, 0, 32'h103, 32'h0, 32'h8000_0000, 32'h0, 0);
    tests_run++; if (b_mask[0] !== 4'b1000 || b_we[0] !== 1'b0 || b_wdata[0] !== 32'h0) begin tests_failed++; $display("FAIL lb_beat: got mask %b we %b wdata %h expected 1000/0/0", b_mask[0], b_we[0], b_wdata[0]); end
    tests_run++; if (r_rdata !== 32'hFFFF_FF80 || resp_cyc !== 2) begin tests_failed++; $display("FAIL lb_sext: got %h cyc %0d expected ffffff80 cyc 2", r_rdata, resp_cyc); end
    do_access(0, 0, 2'b00, 1, 32'h103, 32'h0, 32'h8000_0000, 32'h0, 0);
    tests_run++; if (r_rdata !== 32'h0000_0080) begin tests_failed++; $display("FAIL lbu_zext: got %h expected 00000080", r_rdata); end
    do_access(0, 0, 2'b01, 0, 32'h102, 32'h0, 32'h8001_1234, 32'h0, 0);
    tests_run++; if (r_rdata !== 32'hFFFF_8001 || b_mask[0] !== 4'b1100) begin tests_failed++; $display("FAIL lh_sext: got %h mask %b expected ffff8001/1100", r_rdata, b_mask[0]); end
  endtask

  task automatic test_split_load;
    do_access(0, 0, 2'b10, 0, 32'h102, 32'h0, 32'h5566_7788, 32'h1122_3344, 0);
    tests_run++; if (nbeats !== 2) begin tests_failed++; $display("FAIL slw_beats: got %0d expected 2", nbeats); end
    tests_run++; if (b_addr[0] !== 32'h100 || b_mask[0] !== 4'b1100) begin tests_failed++; $display("FAIL slw_beat0: got %h/%b expected 00000100/1100", b_addr[0], b_mask[0]); end
    tests_run++; if (b_addr[1] !== 32'h104 || b_mask[1] !== 4'b0011 || b_wdata[1] !== 32'h0) begin tests_failed++; $display("FAIL slw_beat1: got %h/%b/%h expected 00000104/0011/0", b_addr[1], b_mask[1], b_wdata[1]); end
    tests_run++; if (r_rdata !== 32'h3344_5566 || resp_cyc !== 3) begin tests_failed++; $display("FAIL slw_resp: got %h cyc %0d expected 33445566 cyc 3", r_rdata, resp_cyc); end
  endtask

  task automatic test_split_store;
    do_access(0, 1, 2'b01, 0, 32'h103, 32'h0000_ABCD, 32'h0, 32'h0, 0);
    tests_run++; if (b_addr[0] !== 32'h100 || b_mask[0] !== 4'b1000 || b_wdata[0] !== 32'hCD00_0000) begin tests_failed++; $display("FAIL ssh_beat0: got %h/%b/%h expected 00000100/1000/cd000000", b_addr[0], b_mask[0], b_wdata[0]); end
    tests_run++; if (b_addr[1] !== 32'h104 || b_mask[1] !== 4'b0001 || b_wdata[1] !== 32'h0000_00AB) begin tests_failed++; $display("FAIL ssh_beat1: got %h/%b/%h expected 00000104/0001/000000ab", b_addr[1], b_mask[1], b_wdata[1]); end
    tests_run++; if (resp_cyc !== 3 || r_rdata !== 32'h0 || b_we[1] !== 1'b1) begin tests_failed++; $display("FAIL ssh_resp: got cyc %0d rdata %h we %b expected 3/0/1", resp_cyc, r_rdata, b_we[1]); end
  endtask

  task automatic test_wait_states;
    do_access(0, 0, 2'b10, 0, 32'h200, 32'h0, 32'hCAFE_F00D, 32'h0, 3);
    tests_run++; if (stable !== 1'b1) begin tests_failed++; $display("FAIL wait_stable: got %b expected 1", stable); end
    tests_run++; if (rdy_low !== 1'b1) begin tests_failed++; $display("FAIL wait_req_ready_low: got %b expected 1", rdy_low); end
    tests_run++; if (nresp !== 1 || resp_cyc !== 5) begin tests_failed++; $display("FAIL wait_resp: got %0d pulses at cyc %0d expected 1 at 5", nresp, resp_cyc); end
    tests_run++; if (r_rdata !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL wait_rdata: got %h expected cafef00d", r_rdata); end
    tests_run++; if (after_rv !== 1'b0 || after_rdy !== 1'b1) begin tests_failed++; $display("FAIL wait_after: got resp_valid %b req_ready %b expected 0/1", after_rv, after_rdy); end
  endtask

  task automatic test_wrap;
    do_access(0, 0, 2'b10, 0, 32'hFFFF_FFFE, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    tests_run++; if (b_addr[0] !== 32'hFFFF_FFFC || b_addr[1] !== 32'h0) begin tests_failed++; $display("FAIL wrap_addr: got %h/%h expected fffffffc/00000000", b_addr[0], b_addr[1]); end
    tests_run++; if (b_mask[1] !== 4'b0011 || r_rdata !== 32'hDEF0_1234) begin tests_failed++; $display("FAIL wrap_data: got mask %b rdata %h expected 0011/def01234", b_mask[1], r_rdata); end
  endtask

  task automatic test_faults;
    do_access(0, 0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 32'h0, 0);
    tests_run++; if (r_fault !== 1'b1 || resp_cyc !== 1 || nbeats !== 0 || r_rdata !== 32'h0) begin tests_failed++; $display("FAIL illegal_size: got fault %b cyc %0d beats %0d rdata %h expected 1/1/0/0", r_fault, resp_cyc, nbeats, r_rdata); end
    do_access(1, 0, 2'b10, 0, 32'h102, 32'h0, 32'h0, 32'h0, 0);
    tests_run++; if (r_fault !== 1'b1 || resp_cyc !== 1 || nbeats !== 0) begin tests_failed++; $display("FAIL nosplit_fault: got fault %b cyc %0d beats %0d expected 1/1/0", r_fault, resp_cyc, nbeats); end
    do_access(1, 0, 2'b10, 0, 32'h104, 32'h0, 32'h0102_0304, 32'h0, 0);
    tests_run++; if (r_fault !== 1'b0 || r_rdata !== 32'h0102_0304 || resp_cyc !== 2) begin tests_failed++; $display("FAIL nosplit_aligned: got fault %b rdata %h cyc %0d expected 0/01020304/2", r_fault, r_rdata, resp_cyc); end
    do_access(1, 0, 2'b01, 0, 32'h102, 32'h0, 32'h7FFF_0000, 32'h0, 0);
    tests_run++; if (r_fault !== 1'b0 || r_rdata !== 32'h0000_7FFF) begin tests_failed++; $display("FAIL nosplit_edge_half: got fault %b rdata %h expected 0/00007fff", r_fault, r_rdata); end
  endtask

  task automatic test_reset_mid_access;
    int seen;
    seen = 0;
    @(negedge clk);
    bus_sp.req_we = 0; bus_sp.req_size = 2'b10; bus_sp.req_uext = 0; bus_sp.req_addr = 32'h102;
    bus_sp.req_valid = 1;
    @(posedge clk);
    @(negedge clk);
    bus_sp.req_valid = 0; bus_sp.mem_ready = 1; bus_sp.mem_rdata = 32'h5566_7788;
    @(posedge clk);
    @(negedge clk);
    bus_sp.mem_ready = 0;
    tests_run++; if (bus_sp.mem_valid !== 1'b1 || bus_sp.mem_addr !== 32'h104) begin tests_failed++; $display("FAIL rmid_in_beat1: got valid %b addr %h expected 1/00000104", bus_sp.mem_valid, bus_sp.mem_addr); end
    #2 reset = 1'b0;
    #1;
    tests_run++; if (bus_sp.mem_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_async_drop: got %b expected 0", bus_sp.mem_valid); end
    repeat (2) begin @(negedge clk); if (bus_sp.resp_valid) seen++; end
    reset = 1'b1;
    repeat (3) begin @(negedge clk); if (bus_sp.resp_valid) seen++; end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL rmid_no_resp: got %0d pulses expected 0", seen); end
    tests_run++; if (bus_sp.req_ready !== 1'b1 || bus_sp.mem_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_idle_after: got ready %b valid %b expected 1/0", bus_sp.req_ready, bus_sp.mem_valid); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_extend();
    test_split_load();
    test_split_store();
    test_wait_states();
    test_wrap();
    test_faults();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
